// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg: shared FSM states and frame constants for the DAC SPI responder
package dac_spi_pkg;
  localparam int INSTR_W = 8;
  localparam int RD_BIT = 7;
  typedef enum logic [1:0] {IDLE, INSTR, DATA, HOLD} state_e;
endpackage

// File: rtl/spi_in_sync.sv
// spi_in_sync: 2-flop synchroniser with previous-value flop and rise/fall pulses
module spi_in_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [2:0] s;
  // two synchroniser stages followed by the previous-value stage
  always_ff @(posedge clk)
    s <= rst ? {3{RST_VAL}} : {s[1:0], d};
  assign rise = s[1] & ~s[2];
  assign fall = ~s[1] & s[2];
endmodule

// File: rtl/dac_spi_slave.sv
// dac_spi_slave: oversampled SPI responder with register file; DAC_SPI_SLAVE_IOUP_EN adds a shadow file copied on IO update
module dac_spi_slave
  import dac_spi_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              cfg_spi_clk,
  input  logic              cfg_rst_in,
  input  logic              dac_spi_clk,
  input  logic              dac_spi_cs,
  input  logic              dac_spi_sdi,
  input  logic              dac_io_updte,
  output logic              dac_spi_sdo,
  output logic              slv_wr_valid,
  output logic [ADDR_W-1:0] slv_wr_addr,
  output logic [DATA_W-1:0] slv_wr_data,
  output logic              slv_frame_err,
  input  logic [ADDR_W-1:0] slv_dbg_addr,
  output logic [DATA_W-1:0] slv_dbg_data
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(DATA_W + 1);
  state_e state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [INSTR_W-1:0] ir, ir_n;
  logic [DATA_W-1:0] sr;
  logic [1:0] sdi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic instr_done, data_done, commit, abort, rd;
  logic [DATA_W-1:0] act [DEPTH];

  spi_in_sync #(.RST_VAL(1'b0)) u_sclk (.clk(cfg_spi_clk), .rst(cfg_rst_in), .d(dac_spi_clk), .rise(sclk_rise), .fall(sclk_fall));
  spi_in_sync #(.RST_VAL(1'b0)) u_cs (.clk(cfg_spi_clk), .rst(cfg_rst_in), .d(dac_spi_cs), .rise(cs_rise), .fall(cs_fall));

  // SDI gets the same two-stage depth as SCLK so the sampled bit lines up with the detected rise
  always_ff @(posedge cfg_spi_clk)
    sdi_s <= cfg_rst_in ? 2'b00 : {sdi_s[0], dac_spi_sdi};

  assign ir_n       = {ir[INSTR_W-2:0], sdi_s[1]};
  assign rd         = ir[RD_BIT];
  assign instr_done = state == INSTR && sclk_rise && cnt == CNT_W'(INSTR_W - 1);
  assign data_done  = state == DATA && sclk_rise && cnt == CNT_W'(DATA_W - 1);
  assign commit     = state == HOLD && cs_rise && !rd;
  assign abort      = cs_rise && (state == DATA || (state == INSTR && cnt != '0));

  // next-state: CS rise always wins over a coincident SCLK edge
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = cs_fall ? INSTR : IDLE;
      INSTR:   state_n = cs_rise ? IDLE : instr_done ? DATA : INSTR;
      DATA:    state_n = cs_rise ? IDLE : data_done ? HOLD : DATA;
      default: state_n = cs_rise ? IDLE : HOLD;
    endcase
  end

  // frame datapath: bit counter, instruction/data shifters, SDO and event pulses
  always_ff @(posedge cfg_spi_clk) begin
    if (cfg_rst_in) begin
      state         <= IDLE;
      cnt           <= '0;
      ir            <= '0;
      sr            <= '0;
      dac_spi_sdo   <= 1'b0;
      slv_wr_valid  <= 1'b0;
      slv_wr_addr   <= '0;
      slv_wr_data   <= '0;
      slv_frame_err <= 1'b0;
    end else begin
      state         <= state_n;
      slv_wr_valid  <= commit;
      slv_frame_err <= abort;
      cnt <= (state == IDLE || instr_done) ? '0 : (sclk_rise && state != HOLD) ? cnt + 1'b1 : cnt;
      if (commit) begin
        slv_wr_addr <= ir[ADDR_W-1:0];
        slv_wr_data <= sr;
      end
      if (state == INSTR && sclk_rise)
        ir <= ir_n;
      if (instr_done)
        sr <= ir_n[RD_BIT] ? act[ir_n[ADDR_W-1:0]] : '0;
      else if (state == DATA && !rd && sclk_rise)
        sr <= {sr[DATA_W-2:0], sdi_s[1]};
      else if (state == DATA && rd && sclk_fall)
        sr <= sr << 1;
      dac_spi_sdo <= (state == DATA && rd) ? (sclk_fall ? sr[DATA_W-1] : dac_spi_sdo) : 1'b0;
    end
  end

`ifdef DAC_SPI_SLAVE_IOUP_EN
  logic io_rise, io_fall;
  logic [DATA_W-1:0] shd [DEPTH];
  spi_in_sync #(.RST_VAL(1'b0)) u_io (.clk(cfg_spi_clk), .rst(cfg_rst_in), .d(dac_io_updte), .rise(io_rise), .fall(io_fall));
  // writes land in the shadow file; IO update copies shadow to active, forwarding a same-cycle write
  always_ff @(posedge cfg_spi_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (cfg_rst_in) begin
        shd[i] <= '0;
        act[i] <= '0;
      end else begin
        if (slv_wr_valid && slv_wr_addr == ADDR_W'(i))
          shd[i] <= slv_wr_data;
        if (io_rise)
          act[i] <= (slv_wr_valid && slv_wr_addr == ADDR_W'(i)) ? slv_wr_data : shd[i];
      end
    end
  end
`else
  // writes update the active file directly
  always_ff @(posedge cfg_spi_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (cfg_rst_in)
        act[i] <= '0;
      else if (slv_wr_valid && slv_wr_addr == ADDR_W'(i))
        act[i] <= slv_wr_data;
    end
  end
`endif

  // registered debug readback of the active file
  always_ff @(posedge cfg_spi_clk)
    slv_dbg_data <= cfg_rst_in ? '0 : act[slv_dbg_addr];
endmodule

// File: tb/tb_dac_spi_slave.sv
// tb_dac_spi_slave: directed SPI frames against dac_spi_slave with hand-computed expectations
module tb_dac_spi_slave;
  localparam int HALF = 6;
  logic clk = 0, rst = 1;
  logic sclk = 0, cs = 1, sdi = 0, io = 0;
  logic sdo, wr_valid, frame_err;
  logic [4:0] wr_addr, dbg_addr = 0;
  logic [31:0] wr_data, dbg_data, rdat;
  int checks = 0, errors = 0;
  int wr_cnt = 0, err_cnt = 0, w0, e0;
  logic [4:0] last_addr = 0;
  logic [31:0] last_data = 0;

  dac_spi_slave dut (
    .cfg_spi_clk(clk), .cfg_rst_in(rst), .dac_spi_clk(sclk), .dac_spi_cs(cs),
    .dac_spi_sdi(sdi), .dac_io_updte(io), .dac_spi_sdo(sdo),
    .slv_wr_valid(wr_valid), .slv_wr_addr(wr_addr), .slv_wr_data(wr_data),
    .slv_frame_err(frame_err), .slv_dbg_addr(dbg_addr), .slv_dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_valid) begin
      wr_cnt <= wr_cnt + 1;
      last_addr <= wr_addr;
      last_data <= wr_data;
    end
    if (frame_err) err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic sclk_bit(input logic b, output logic s);
    sdi = b;
    repeat (HALF) @(negedge clk);
    s = sdo;
    sclk = 1;
    repeat (HALF) @(negedge clk);
    sclk = 0;
  endtask

  task automatic spi_frame(input logic [7:0] ins, input logic [63:0] dat, input int nd, output logic [31:0] rd);
    logic s;
    rd = 0;
    cs = 0;
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < 8; k++) sclk_bit(ins[7-k], s);
    for (int k = 0; k < nd; k++) begin
      sclk_bit(dat[63-k], s);
      if (k < 32) rd = {rd[30:0], s};
    end
    repeat (HALF) @(negedge clk);
    cs = 1;
    repeat (20) @(negedge clk);
  endtask

  task automatic dbg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    dbg_addr = a;
    repeat (3) @(negedge clk);
    chk(tag, dbg_data, exp);
  endtask

  task automatic snap;
    w0 = wr_cnt;
    e0 = err_cnt;
  endtask

  initial begin
    logic s;
    repeat (5) @(negedge clk);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_sdo", sdo, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_dbg", dbg_data, 0);
    rst = 0;
    repeat (10) @(negedge clk);

    snap();
    spi_frame(8'h01, {32'h0A0B0C0D, 32'h0}, 32, rdat);
    chk("wr1_count", wr_cnt - w0, 1);
    chk("wr1_addr", last_addr, 5'd1);
    chk("wr1_data", last_data, 32'h0A0B0C0D);
    chk("wr1_err", err_cnt - e0, 0);
`ifdef DAC_SPI_SLAVE_IOUP_EN
    dbg("wr1_dbg", 5'd1, 32'h0);
    io = 1; repeat (8) @(negedge clk); io = 0; repeat (8) @(negedge clk);
`endif
    dbg("wr1_dbg_act", 5'd1, 32'h0A0B0C0D);

    snap();
    spi_frame(8'h81, 64'h0, 32, rdat);
    chk("rd1_data", rdat, 32'h0A0B0C0D);
    chk("rd1_no_wr", wr_cnt - w0, 0);
    chk("rd1_sdo_idle", sdo, 0);

    snap();
    cs = 0; repeat (10) @(negedge clk); cs = 1; repeat (20) @(negedge clk);
    chk("empty_cs_err", err_cnt - e0, 0);
    chk("empty_cs_wr", wr_cnt - w0, 0);

    snap();
    spi_frame(8'h01, 64'hFFFFFFFF_FFFFFFFF, 12, rdat);
    chk("trunc_err", err_cnt - e0, 1);
    chk("trunc_no_wr", wr_cnt - w0, 0);
    dbg("trunc_keep", 5'd1, 32'h0A0B0C0D);

    snap();
    spi_frame(8'h02, {32'h12345678, 32'h0}, 32, rdat);
    chk("wr2_count", wr_cnt - w0, 1);
`ifdef DAC_SPI_SLAVE_IOUP_EN
    dbg("wr2_dbg_pre", 5'd2, 32'h0);
`else
    dbg("wr2_dbg_pre", 5'd2, 32'h12345678);
`endif
    io = 1; repeat (8) @(negedge clk); io = 0; repeat (8) @(negedge clk);
    dbg("wr2_dbg_post", 5'd2, 32'h12345678);

    snap();
    cs = 0;
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < 8; k++) sclk_bit(k == 7, s);
    for (int k = 0; k < 4; k++) sclk_bit(1'b1, s);
    rst = 1; repeat (3) @(negedge clk); rst = 0;
    repeat (10) @(negedge clk);
    cs = 1;
    repeat (20) @(negedge clk);
    chk("rstmid_no_wr", wr_cnt - w0, 0);
    chk("rstmid_no_err", err_cnt - e0, 0);
    dbg("rstmid_cleared", 5'd1, 32'h0);

    snap();
    spi_frame(8'h03, {32'hFFFF0000, 32'h0}, 32, rdat);
    chk("wr3_count", wr_cnt - w0, 1);
    chk("wr3_addr", last_addr, 5'd3);
    chk("wr3_data", last_data, 32'hFFFF0000);

    snap();
    spi_frame(8'h04, {32'hCAFEBABE, 16'h1234, 16'h0}, 48, rdat);
    chk("long_count", wr_cnt - w0, 1);
    chk("long_addr", last_addr, 5'd4);
    chk("long_data", last_data, 32'hCAFEBABE);
    chk("long_err", err_cnt - e0, 0);
`ifdef DAC_SPI_SLAVE_IOUP_EN
    io = 1; repeat (8) @(negedge clk); io = 0; repeat (8) @(negedge clk);
`endif
    dbg("long_dbg", 5'd4, 32'hCAFEBABE);
    dbg("wr3_dbg", 5'd3, 32'hFFFF0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
